// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bundles the two requester ports, the byte-wide data-memory
// port and the busy flag of dmem_arbiter.
//   pN_req/we/size/addr/wdata : requester N command (N = 0,1)
//   pN_ack/err/rdata          : requester N one-cycle completion response
//   mem_en/we/addr/wdata      : byte memory command, mem_rdata one cycle later
//   busy                      : arbiter not idle
// Modports: slave = arbiter view, master = requester/memory environment view.
interface dmem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [1:0]  p0_size;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_ack;
  logic        p0_err;
  logic [31:0] p0_rdata;

  logic        p1_req;
  logic        p1_we;
  logic [1:0]  p1_size;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_ack;
  logic        p1_err;
  logic [31:0] p1_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  modport slave (
    input  p0_req, p0_we, p0_size, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_size, p1_addr, p1_wdata,
    input  mem_rdata,
    output p0_ack, p0_err, p0_rdata,
    output p1_ack, p1_err, p1_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output p0_req, p0_we, p0_size, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_size, p1_addr, p1_wdata,
    output mem_rdata,
    input  p0_ack, p0_err, p0_rdata,
    input  p1_ack, p1_err, p1_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter between two requesters sharing a byte-wide
// data memory. Byte/half/word accesses are serialised big-endian, one byte per
// cycle; out-of-range or illegal-size accesses are answered with err, no access.
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : dmem_arbiter_if.slave (requester ports, memory port, busy)
// Parameters: OFFSET_ADDR = bus address of memory byte 0, DEPTH = bytes.
module dmem_arbiter #(
  parameter int unsigned OFFSET_ADDR = 1000,
  parameter int unsigned DEPTH       = 64
) (
  input logic           clk,
  input logic           rst,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, XFER, LAST, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_q, last_d;      // 1 = port 1 granted last
  logic        gnt_q, gnt_d;
  logic        we_q, we_d;
  logic [1:0]  cnt_q, cnt_d;        // bytes still to issue after the current one
  logic [31:0] wsh_q, wsh_d;        // remaining write bytes, left-aligned
  logic [31:0] acc_q, acc_d;
  logic        rd_pend_q, rd_pend_d;
  logic        mem_en_q, mem_en_d;
  logic        mem_we_q, mem_we_d;
  logic [5:0]  mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        ack0_q, ack0_d, ack1_q, ack1_d;
  logic        err0_q, err0_d, err1_q, err1_d;
  logic [31:0] rdata_q, rdata_d;
  logic        busy_q, busy_d;

  // Request selection and decode for the IDLE grant
  logic        sel, sel_we, sel_err, go_resp, resp_err;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata, local_addr, aligned;
  logic [2:0]  n;

  always_comb begin
    sel       = (bus.p0_req && bus.p1_req) ? ~last_q : bus.p1_req;
    sel_we    = sel ? bus.p1_we    : bus.p0_we;
    sel_size  = sel ? bus.p1_size  : bus.p0_size;
    sel_addr  = sel ? bus.p1_addr  : bus.p0_addr;
    sel_wdata = sel ? bus.p1_wdata : bus.p0_wdata;
    case (sel_size)
      2'd0:    begin n = 3'd1; aligned = {sel_wdata[7:0], 24'h0};  end
      2'd1:    begin n = 3'd2; aligned = {sel_wdata[15:0], 16'h0}; end
      default: begin n = 3'd4; aligned = sel_wdata;                end
    endcase
    local_addr = sel_addr - 32'(OFFSET_ADDR);
    // local_addr[31] catches underflow; below 2^31 the +n-1 cannot wrap
    sel_err = (sel_size == 2'd3) || local_addr[31] ||
              ((local_addr + 32'(n) - 32'd1) >= 32'(DEPTH));
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    wsh_d       = wsh_q;
    acc_d       = rd_pend_q ? {acc_q[23:0], bus.mem_rdata} : acc_q;
    rd_pend_d   = mem_en_q & ~mem_we_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    go_resp     = 1'b0;
    resp_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.p0_req || bus.p1_req) begin
          gnt_d   = sel;
          last_d  = sel;
          we_d    = sel_we;
          acc_d   = '0;
          rdata_d = '0;
          if (sel_err) begin
            state_d  = RESP;
            go_resp  = 1'b1;
            resp_err = 1'b1;
          end else begin
            state_d     = XFER;
            mem_en_d    = 1'b1;
            mem_we_d    = sel_we;
            mem_addr_d  = local_addr[5:0];
            mem_wdata_d = aligned[31:24];
            wsh_d       = {aligned[23:0], 8'h0};
            cnt_d       = 2'(n - 3'd1);
          end
        end
      end
      XFER: begin
        if (cnt_q == 2'd0) begin
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (we_q) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = LAST;
          end
        end else begin
          cnt_d       = cnt_q - 2'd1;
          mem_addr_d  = mem_addr_q + 6'd1;
          mem_wdata_d = wsh_q[31:24];
          wsh_d       = {wsh_q[23:0], 8'h0};
        end
      end
      LAST: begin
        // final read byte arrives now; publish the completed accumulator
        state_d = RESP;
        go_resp = 1'b1;
        rdata_d = acc_d;
      end
      default: state_d = IDLE;
    endcase

    ack0_d = go_resp & ~gnt_d;
    ack1_d = go_resp &  gnt_d;
    err0_d = go_resp & ~gnt_d & resp_err;
    err1_d = go_resp &  gnt_d & resp_err;
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      gnt_q       <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      wsh_q       <= '0;
      acc_q       <= '0;
      rd_pend_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      err0_q      <= 1'b0;
      err1_q      <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      gnt_q       <= gnt_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      wsh_q       <= wsh_d;
      acc_q       <= acc_d;
      rd_pend_q   <= rd_pend_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      err0_q      <= err0_d;
      err1_q      <= err1_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.p0_ack    = ack0_q;
  assign bus.p1_ack    = ack1_q;
  assign bus.p0_err    = err0_q;
  assign bus.p1_err    = err1_q;
  assign bus.p0_rdata  = rdata_q;
  assign bus.p1_rdata  = rdata_q;
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.busy      = busy_q;

endmodule
